// File: rtl/cfg_pkg.sv
// cfg_pkg: shared constants and loader state encoding for the CB programming path
package cfg_pkg;
  localparam int CB_CHAIN_LEN = 69;
  localparam int CFG_WORD_W = 32;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} ld_state_e;
endpackage

// File: rtl/cfg_piso.sv
// cfg_piso: parallel-in/serial-out word register with a bits-left count
module cfg_piso #(
  parameter int WORD_W = 32,
  parameter int LEFT_W = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [LEFT_W-1:0] left_i,
  output logic              bit_o,
  output logic [LEFT_W-1:0] left_o
);
  logic [WORD_W-1:0] shreg_q;
  logic [LEFT_W-1:0] left_q;
  // load wins over shift so a word reloaded on the final bit of the previous one leaves no gap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shreg_q <= '0;
      left_q  <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
      left_q  <= left_i;
    end else if (shift_i) begin
      shreg_q <= shreg_q >> 1;
      left_q  <= left_q - 1'b1;
    end
  assign bit_o  = shreg_q[0];
  assign left_o = left_q;
endmodule

// File: rtl/cfg_bitstream_loader.sv
// cfg_bitstream_loader: serializes handshaked config words LSB-first onto the CB prog chain
module cfg_bitstream_loader
  import cfg_pkg::*;
#(
  parameter int WORD_W    = CFG_WORD_W,
  parameter int CHAIN_LEN = CB_CHAIN_LEN,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              prog_dout,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt
);
  localparam int LEFT_W = $clog2(WORD_W + 1);
  ld_state_e state_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, remain;
  logic [LEFT_W-1:0] left, left_ld;
  logic prog_dout_q, prog_en_q, done_q;
  logic piso_bit, last_bit, more, hs, finishing, shifting;
  // handshake, shift qualification and the bit budget for the next word
  always_comb begin
    last_bit   = state_q == SHIFT && left == LEFT_W'(1);
    more       = (bit_cnt_q + 1'b1) < CNT_W'(CHAIN_LEN);
    word_ready = state_q == LOAD || (last_bit && more);
    hs         = word_valid && word_ready && !abort;
    finishing  = state_q == SHIFT && bit_cnt_q == CNT_W'(CHAIN_LEN);
    shifting   = state_q == SHIFT && !finishing && !abort;
    bit_cnt_d  = bit_cnt_q + CNT_W'(shifting);
    remain     = CNT_W'(CHAIN_LEN) - bit_cnt_d;
    left_ld    = remain > CNT_W'(WORD_W) ? LEFT_W'(WORD_W) : LEFT_W'(remain);
  end
  cfg_piso #(.WORD_W(WORD_W), .LEFT_W(LEFT_W)) u_piso (
    .clk    (prog_clk),
    .rst    (rst),
    .load_i (hs),
    .shift_i(shifting),
    .data_i (word_data),
    .left_i (left_ld),
    .bit_o  (piso_bit),
    .left_o (left)
  );
  // load sequencing; prog_dout holds its last value whenever prog_en drops
  always_ff @(posedge prog_clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      prog_dout_q <= 1'b0;
      prog_en_q   <= 1'b0;
      done_q      <= 1'b0;
    end else if (state_q == IDLE) begin
      prog_en_q <= 1'b0;
      if (start) begin
        state_q   <= LOAD;
        bit_cnt_q <= '0;
        done_q    <= 1'b0;
      end
    end else if (abort || finishing) begin
      state_q   <= IDLE;
      prog_en_q <= 1'b0;
      done_q    <= finishing && !abort;
    end else begin
      prog_en_q <= shifting;
      if (shifting) prog_dout_q <= piso_bit;
      bit_cnt_q <= bit_cnt_d;
      state_q   <= (hs || (state_q == SHIFT && !(last_bit && more))) ? SHIFT : LOAD;
    end
  assign prog_dout = prog_dout_q;
  assign prog_en   = prog_en_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign bit_cnt   = bit_cnt_q;
endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// tb_cfg_bitstream_loader: stream-model checked bench for the CB bitstream loader
module tb_cfg_bitstream_loader;
  localparam int N = 69;
  localparam int W = 32;
  logic prog_clk = 0, rst = 1, start = 0, abort = 0, word_valid = 0;
  logic [W-1:0] word_data = '0;
  logic word_ready, prog_dout, prog_en, busy, done;
  logic [6:0] bit_cnt;
  int checks = 0, passed = 0;
  always #5 prog_clk = ~prog_clk;
  cfg_bitstream_loader dut (
    .prog_clk  (prog_clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .prog_dout (prog_dout),
    .prog_en   (prog_en),
    .busy      (busy),
    .done      (done),
    .bit_cnt   (bit_cnt)
  );
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // model: a load is a bit stream built from accepted words, trimmed to N bits, emitted one per cycle
  bit m_run = 0, m_done = 0, m_en = 0, m_dout = 0;
  int m_loaded = 0, m_emit = 0, m_hs = 0;
  logic [N-1:0] m_stream = '0;
  wire m_ready = m_run && m_loaded < N && (m_loaded - m_emit) <= 1;
  always @(posedge prog_clk or posedge rst)
    if (rst) begin
      m_run <= 0; m_done <= 0; m_en <= 0; m_dout <= 0;
      m_loaded <= 0; m_emit <= 0; m_hs <= 0;
    end else if (!m_run) begin
      m_en <= 0;
      if (start) begin
        m_run <= 1; m_done <= 0; m_loaded <= 0; m_emit <= 0; m_hs <= 0;
      end
    end else if (abort) begin
      m_run <= 0; m_en <= 0;
    end else if (m_emit == N) begin
      m_run <= 0; m_en <= 0; m_done <= 1;
    end else begin
      m_en <= m_loaded > m_emit;
      if (m_loaded > m_emit) begin
        m_dout <= m_stream[m_emit];
        m_emit <= m_emit + 1;
      end
      if (word_valid && m_ready) begin
        for (int i = 0; i < W; i++)
          if (i < N - m_loaded) m_stream[m_loaded + i] <= word_data[i];
        m_loaded <= m_loaded + ((N - m_loaded) < W ? (N - m_loaded) : W);
        m_hs <= m_hs + 1;
      end
    end
  // CB chain capture and prog_en run/gap statistics per load
  logic [N-1:0] cap = '0;
  int run = 0, maxrun = 0, gaps = 0, gap_at = 0;
  always @(posedge prog_clk)
    if (start && !busy) begin
      cap <= '0; run <= 0; maxrun <= 0; gaps <= 0; gap_at <= 0;
    end else begin
      if (prog_en) cap <= {prog_dout, cap[N-1:1]};
      run <= prog_en ? run + 1 : 0;
      if (prog_en && run + 1 > maxrun) maxrun <= run + 1;
      if (busy && !prog_en && bit_cnt > 0 && bit_cnt < 7'(N)) begin
        gaps <= gaps + 1;
        gap_at <= int'(bit_cnt);
      end
    end
  // every-cycle comparison against the model
  always @(negedge prog_clk)
    if (!rst) begin
      chk("word_ready", word_ready, m_ready);
      chk("prog_en", prog_en, m_en);
      chk("prog_dout", prog_dout, m_dout);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("bit_cnt", bit_cnt, m_emit);
    end
  task automatic run_load(input logic [W-1:0] w0, w1, w2, input int stall_n, abort_at, rst_at, sstart_at);
    logic [W-1:0] w [3];
    int idx = 0, held = 0, cyc = 0;
    bit ab = 0, ss = 0, stop = 0;
    w[0] = w0; w[1] = w1; w[2] = w2;
    @(negedge prog_clk);
    start = 1; word_valid = 1; word_data = w0;
    @(negedge prog_clk);
    while (cyc < 400 && busy && !stop) begin
      start = 0; abort = 0;
      if (rst_at >= 0 && int'(bit_cnt) == rst_at) begin
        #2 rst = 1;
        #1;
        chk("rst_prog_en", prog_en, 0);
        chk("rst_prog_dout", prog_dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        chk("rst_word_ready", word_ready, 0);
        chk("rst_done", done, 0);
        @(negedge prog_clk);
        rst = 0;
        stop = 1;
      end else begin
        if (abort_at >= 0 && !ab && int'(bit_cnt) == abort_at) begin abort = 1; ab = 1; end
        if (sstart_at >= 0 && !ss && int'(bit_cnt) == sstart_at) begin start = 1; ss = 1; end
        word_data = w[idx < 3 ? idx : 2];
        word_valid = idx < 3;
        if (idx == 1 && word_ready && held < stall_n) begin word_valid = 0; held++; end
        @(posedge prog_clk);
        if (word_valid && word_ready && !abort) idx++;
        @(negedge prog_clk);
        cyc++;
      end
    end
    start = 0; abort = 0; word_valid = 0;
    chk("load_terminated", busy, 0);
  endtask
  initial begin
    repeat (2) @(negedge prog_clk);
    rst = 0;
    chk("reset_word_ready", word_ready, 0);
    chk("reset_prog_en", prog_en, 0);
    chk("reset_prog_dout", prog_dout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bit_cnt", bit_cnt, 0);
    run_load(32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 0, -1, -1, -1);
    chk("nom_cap", cap, {5'h1F, 32'h12345678, 32'hDEADBEEF});
    chk("nom_done", done, 1);
    chk("nom_bit_cnt", bit_cnt, N);
    chk("nom_en_run", maxrun, N);
    chk("nom_gaps", gaps, 0);
    chk("nom_handshakes", m_hs, 3);
    run_load(32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 3, -1, -1, -1);
    chk("stall_cap", cap, {5'h1F, 32'h12345678, 32'hDEADBEEF});
    chk("stall_gaps", gaps, 3);
    chk("stall_gap_at", gap_at, 32);
    chk("stall_en_run", maxrun, 37);
    chk("stall_done", done, 1);
    run_load(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h00000015, 0, 40, -1, -1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_prog_en", prog_en, 0);
    chk("abort_bit_cnt", bit_cnt, 40);
    run_load(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h00000015, 0, -1, -1, -1);
    chk("reload_cap", cap, {5'h15, 32'h0F0F0F0F, 32'hA5A5A5A5});
    chk("reload_done", done, 1);
    run_load(32'h13579BDF, 32'h2468ACE0, 32'h0000000A, 0, -1, 10, -1);
    repeat (3) @(negedge prog_clk);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_done", done, 0);
    run_load(32'h13579BDF, 32'h2468ACE0, 32'hFFFFFFEA, 0, -1, -1, 20);
    chk("sstart_cap", cap, {5'h0A, 32'h2468ACE0, 32'h13579BDF});
    chk("sstart_bit_cnt", bit_cnt, N);
    chk("sstart_done", done, 1);
    chk("sstart_handshakes", m_hs, 3);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/cfg_bitstream_loader.md
Name: cfg_bitstream_loader

Overview:
Upstream configuration stage for the connection-box (CB) serial programming chain. Accepts configuration words over a valid/ready handshake and serializes them LSB-first onto the CB chain's prog_in/prog_en pins for exactly CHAIN_LEN bits, then flags completion. Sits between the host/config memory interface and the first CB in the chain; its outputs feed the CB prog_in/prog_en inputs directly on the same prog_clk.

Parameters:
WORD_W, 32, width of each incoming configuration word.
CHAIN_LEN, 69, total bits to shift into the chain (one CB = 69).
CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
prog_clk  in  1  configuration clock; everything sampled on posedge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  single-cycle request to begin a load; honoured only in IDLE.
abort  in  1  synchronous cancel of an in-progress load.
word_data  in  WORD_W  configuration word; bit 0 is shifted first.
word_valid  in  1  word_data is valid.
word_ready  out  1  loader accepts word_data this cycle.
prog_dout  out  1  serial data to the CB prog_in.
prog_en  out  1  shift enable to the CB prog_en.
busy  out  1  high in LOAD or SHIFT.
done  out  1  sticky; set when CHAIN_LEN bits have been shifted, cleared by start, abort or rst.
bit_cnt  out  CNT_W  bits shifted so far in the current load.

Behaviour:
- Reset (async, rst=1): state=IDLE; word_ready=0, prog_dout=0, prog_en=0, busy=0, done=0, bit_cnt=0; the shift register and the bits-left counter are cleared.
- States: IDLE, LOAD, SHIFT.
- IDLE: start=1 -> LOAD; bit_cnt<=0; done<=0. start while busy is ignored.
- LOAD: word_ready=1. On word_valid&word_ready, capture word_data into shreg. Set word_left = min(WORD_W, CHAIN_LEN-bit_cnt), then go to SHIFT.
- SHIFT, each cycle: prog_dout<=shreg[0]; prog_en<=1; shreg>>=1; word_left--; bit_cnt++.
- Output registering: prog_dout and prog_en are registered. A word accepted at edge k drives its bit 0 valid after edge k+1. The CB samples it at edge k+2.
- Back-to-back words: word_ready is also high in SHIFT when word_left==1 and bit_cnt+1<CHAIN_LEN. A handshake in that cycle reloads shreg, so there is no bubble between words.
- Stall: if word_left reaches 0 with no new word accepted, go to LOAD. prog_en<=0 for every stalled cycle and prog_dout holds its value. The CB does not shift while prog_en=0.
- Completion: when bit_cnt reaches CHAIN_LEN, go to IDLE the next cycle. prog_en<=0 and done<=1. word_ready is never asserted on the completing cycle.
- Partial last word: bits above word_left are discarded. For CHAIN_LEN=69 and WORD_W=32, the loader consumes exactly 3 words and uses 5 bits of the third.
- With word_valid held high throughout, prog_en is high for exactly CHAIN_LEN consecutive cycles.
- abort in LOAD or SHIFT: go to IDLE the next edge; prog_en<=0, word_ready=0, done stays 0, bit_cnt holds for debug. abort in IDLE has no effect.
- abort and a handshake in the same cycle: abort wins and the word is dropped.
- start and abort in the same cycle in IDLE: start is taken.
- rst mid-load forces all reset values immediately. A partially programmed CB is the upstream controller's responsibility; it must re-run the load.
- bit_cnt saturates at CHAIN_LEN and never wraps.

Decomposition:
- Shared package cfg_pkg holds: CB_CHAIN_LEN=69, CFG_WORD_W=32, and the loader state enum (IDLE/LOAD/SHIFT).
- One natural sub-module: cfg_piso, a WORD_W parallel-in/serial-out register with load, shift and bits-left count.
- The top level holds the FSM, the handshake logic and bit_cnt.

Test Plan:
- Nominal load: rst, start, then words 0xDEADBEEF, 0x12345678, 0xFFFFFFFF with valid always high. Expect prog_en high for 69 consecutive cycles and done=1. The CB-model capture equals {5'h1F, 32'h12345678, 32'hDEADBEEF}; the upper 27 bits of word 3 are ignored.
- Stall: withhold word_valid for 3 cycles before word 2. Expect prog_en=0 for exactly 3 cycles and bit_cnt frozen at 32. The final CB contents are identical to the nominal case.
- Handshake: check that word_ready rises only in LOAD or on the last bit of a word. Exactly 3 handshakes occur per load, and none on the completing cycle.
- Abort: assert abort at bit_cnt=40. Expect prog_en=0 the next cycle, done=0, busy=0. A following start and 3 words must load cleanly.
- Reset mid-shift: assert rst asynchronously between edges at bit_cnt=10. All outputs drop to reset values immediately; start is required afterwards.
- start pulsed during SHIFT: ignored, with bit_cnt continuing monotonically to 69.
